// File: rtl/periph_bus_initiator.sv
// Initiator for the peripheral valid/ready register bus: one command in, one bus access (two for RMW) out, result back.
// Optional read-modify-write path built only when the RMW_EN macro is defined.
module periph_bus_initiator #(
    parameter int TIMEOUT = 64,
    parameter int TO_W    = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic        cmd_rmw_i,
    input  logic [31:0] cmd_mask_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_rdata_o,
    output logic        res_err_o,
    output logic        req_valid_o,
    input  logic        req_ready_i,
    output logic        we_o,
    output logic [31:0] addr_o,
    output logic [31:0] data_o,
    input  logic [31:0] data_i,
    input  logic        rsp_valid_i,
    output logic        rsp_ready_o,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid-side payload is held stable while valid is high and ready is low.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          r_state, w_state_nxt;
    logic [TO_W-1:0] r_cnt, w_cnt_nxt;
    logic            r_req_valid, w_req_valid_nxt;
    logic            r_rsp_ready, w_rsp_ready_nxt;
    logic            r_res_valid, w_res_valid_nxt;
    logic [31:0]     r_res_rdata, w_res_rdata_nxt;
    logic            r_res_err, w_res_err_nxt;
    logic            r_we, w_we_nxt;
    logic [31:0]     r_addr, w_addr_nxt;
    logic [31:0]     r_data, w_data_nxt;

    logic            w_accept;
    logic            w_rmw_wr;
    logic            w_timeout;
    logic [31:0]     w_rsp_cap;
    logic            w_cmd_rmw;
    logic            w_rmw_read;
    logic            w_rmw_write;
    logic [31:0]     w_merge;

    assign w_timeout = (r_cnt == TO_LAST);
    assign w_rsp_cap = r_we ? 32'h0 : data_i;

`ifdef RMW_EN
    logic        r_rmw;
    logic        r_phase;
    logic [31:0] r_wdata;
    logic [31:0] r_mask;

    assign w_cmd_rmw   = cmd_rmw_i;
    assign w_rmw_read  = r_rmw & ~r_phase;
    assign w_rmw_write = r_rmw & r_phase;
    assign w_merge     = (data_i & ~r_mask) | (r_wdata & r_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rmw   <= 1'b0;
            r_phase <= 1'b0;
            r_wdata <= 32'h0;
            r_mask  <= 32'h0;
        end else if (w_accept) begin
            r_rmw   <= cmd_rmw_i;
            r_phase <= 1'b0;
            r_wdata <= cmd_wdata_i;
            r_mask  <= cmd_mask_i;
        end else if (w_rmw_wr) begin
            r_phase <= 1'b1;
        end
    end
`else
    logic w_unused_rmw;

    assign w_cmd_rmw    = 1'b0;
    assign w_rmw_read   = 1'b0;
    assign w_rmw_write  = 1'b0;
    assign w_merge      = 32'h0;
    assign w_unused_rmw = ^{cmd_rmw_i, cmd_mask_i, w_rmw_wr};
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_req_valid_nxt = r_req_valid;
        w_rsp_ready_nxt = r_rsp_ready;
        w_res_valid_nxt = r_res_valid;
        w_res_rdata_nxt = r_res_rdata;
        w_res_err_nxt   = r_res_err;
        w_we_nxt        = r_we;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_accept        = 1'b0;
        w_rmw_wr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    w_accept        = 1'b1;
                    w_state_nxt     = S_REQ;
                    w_cnt_nxt       = '0;
                    w_req_valid_nxt = 1'b1;
                    // An RMW always starts with a read of the target word.
                    w_we_nxt        = cmd_we_i & ~w_cmd_rmw;
                    w_addr_nxt      = cmd_addr_i;
                    w_data_nxt      = cmd_wdata_i;
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    w_req_valid_nxt = 1'b0;
                    w_rsp_ready_nxt = 1'b1;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_RSP;
                end else if (w_timeout) begin
                    w_req_valid_nxt = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                    w_res_rdata_nxt = 32'h0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_RSP: begin
                if (rsp_valid_i) begin
                    w_rsp_ready_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    if (w_rmw_read) begin
                        w_rmw_wr        = 1'b1;
                        w_res_rdata_nxt = w_rsp_cap;
                        w_data_nxt      = w_merge;
                        w_we_nxt        = 1'b1;
                        w_req_valid_nxt = 1'b1;
                        w_state_nxt     = S_REQ;
                    end else begin
                        // The RMW write phase keeps the read value as its result.
                        if (!w_rmw_write) begin
                            w_res_rdata_nxt = w_rsp_cap;
                        end
                        w_res_valid_nxt = 1'b1;
                        w_res_err_nxt   = 1'b0;
                        w_state_nxt     = S_DONE;
                    end
                end else if (w_timeout) begin
                    w_rsp_ready_nxt = 1'b0;
                    w_res_valid_nxt = 1'b1;
                    w_res_err_nxt   = 1'b1;
                    w_res_rdata_nxt = 32'h0;
                    w_state_nxt     = S_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    w_res_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_req_valid <= 1'b0;
            r_rsp_ready <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_rdata <= 32'h0;
            r_res_err   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= 32'h0;
            r_data      <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_rsp_ready <= w_rsp_ready_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_res_rdata <= w_res_rdata_nxt;
            r_res_err   <= w_res_err_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
        end
    end

    assign cmd_ready_o = (r_state == S_IDLE);
    assign res_valid_o = r_res_valid;
    assign res_rdata_o = r_res_rdata;
    assign res_err_o   = r_res_err;
    assign req_valid_o = r_req_valid;
    assign rsp_ready_o = r_rsp_ready;
    assign we_o        = r_we;
    assign addr_o      = r_addr;
    assign data_o      = r_data;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_periph_bus_initiator.sv
// Directed bench for periph_bus_initiator (TIMEOUT = 8): vector table plus hand sequences
// for result back-pressure, reset in REQ and, with RMW_EN, the read-modify-write path.
module tb_periph_bus_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_rmw_i;
    logic [31:0] cmd_addr_i, cmd_wdata_i, cmd_mask_i;
    logic        res_valid_o, res_ready_i, res_err_o;
    logic [31:0] res_rdata_o;
    logic        req_valid_o, req_ready_i, we_o;
    logic [31:0] addr_o, data_o, data_i;
    logic        rsp_valid_i, rsp_ready_o;
    logic [1:0]  dbg_state_o;

    int total = 0;
    int bad   = 0;

    periph_bus_initiator #(.TIMEOUT(8), .TO_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_rmw_i(cmd_rmw_i),
        .cmd_mask_i(cmd_mask_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_rdata_o(res_rdata_o), .res_err_o(res_err_o), .req_valid_o(req_valid_o),
        .req_ready_i(req_ready_i), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
        .dbg_state_o(dbg_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rresp;
        int          stall;
        int          delay;
        logic        never_rsp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rsp_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_rmw_i = 1'b0;
        cmd_addr_i = 32'h0; cmd_wdata_i = 32'h0; cmd_mask_i = 32'h0;
        res_ready_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; data_i = 32'h0;
    endtask

    // driver: one command against a responder with configurable stalls
    task automatic run_vec(input vec_t v);
        int cyc, req_wait, rsp_wait, rsp_cyc;
        check("cmd_ready_idle", cmd_ready_o, 1);
        cmd_valid_i = 1'b1; cmd_we_i = v.we; cmd_addr_i = v.addr; cmd_wdata_i = v.wdata;
        tick();
        idle_inputs();
        cyc = 1; req_wait = 0; rsp_wait = 0; rsp_cyc = 0;
        check("req_valid_cycle1", req_valid_o, 1);
        while (!res_valid_o && cyc < 200) begin
            if (req_valid_o) begin
                check("addr_stable", addr_o, v.addr);
                check("we_stable", we_o, v.we);
                if (v.we) check("data_stable", data_o, v.wdata);
            end
            req_ready_i = req_valid_o && (req_wait >= v.stall);
            if (req_valid_o) req_wait++;
            rsp_valid_i = rsp_ready_o && !v.never_rsp && (rsp_wait >= v.delay);
            data_i = rsp_valid_i ? v.rresp : 32'hDEAD_BEEF;
            if (rsp_ready_o) begin
                rsp_wait++;
                rsp_cyc++;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        check("res_valid_seen", res_valid_o, 1);
        check("latency", cyc, v.exp_lat);
        check("rsp_ready_cycles", rsp_cyc, v.exp_rsp_cyc);
        check("res_rdata", res_rdata_o, v.exp_rdata);
        check("res_err", res_err_o, v.exp_err);
        check("req_valid_done", req_valid_o, 0);
        check("rsp_ready_done", rsp_ready_o, 0);
        check("cmd_ready_done", cmd_ready_o, 0);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("res_valid_cleared", res_valid_o, 0);
        check("cmd_ready_back", cmd_ready_o, 1);
    endtask

    initial begin
        // we, addr, wdata, rresp, stall, delay, never, exp_rdata, exp_err, exp_lat, exp_rsp_cyc
        vecs[0] = '{1'b1, 32'h04, 32'h0000_A5A5, 32'h0,         0,    0, 1'b0, 32'h0,         1'b0, 3,  1};
        vecs[1] = '{1'b0, 32'h08, 32'h0,         32'h0000_1234, 5,    0, 1'b0, 32'h0000_1234, 1'b0, 8,  1};
        vecs[2] = '{1'b0, 32'h10, 32'h0,         32'hCAFE_F00D, 0,    3, 1'b0, 32'hCAFE_F00D, 1'b0, 6,  4};
        vecs[3] = '{1'b0, 32'h0C, 32'h0,         32'h1111_1111, 0,    0, 1'b1, 32'h0,         1'b1, 10, 8};
        vecs[4] = '{1'b1, 32'h14, 32'h0000_0001, 32'h5555_5555, 2,    1, 1'b0, 32'h0,         1'b0, 6,  2};
        vecs[5] = '{1'b0, 32'h18, 32'h0,         32'h0000_0077, 7,    0, 1'b0, 32'h0000_0077, 1'b0, 10, 1};
        vecs[6] = '{1'b0, 32'h1C, 32'h0,         32'h0000_0088, 0,    7, 1'b0, 32'h0000_0088, 1'b0, 10, 8};
        vecs[7] = '{1'b1, 32'h24, 32'h1234_5678, 32'h0,         1000, 0, 1'b0, 32'h0,         1'b1, 9,  0};
        vecs[8] = '{1'b0, 32'h20, 32'h0,         32'h0000_ABCD, 0,    0, 1'b0, 32'h0000_ABCD, 1'b0, 3,  1};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_valid", req_valid_o, 0);
        check("rst_rsp_ready", rsp_ready_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_res_rdata", res_rdata_o, 0);
        check("rst_res_err", res_err_o, 0);
        check("rst_we", we_o, 0);
        check("rst_addr", addr_o, 0);
        check("rst_data", data_o, 0);
        check("rst_cmd_ready", cmd_ready_o, 1);
        check("rst_state", dbg_state_o, 0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // result back-pressure with a second command waiting
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 32'h30;
        tick();
        cmd_valid_i = 1'b0;
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b1; data_i = 32'h0000_0099;
        tick();
        rsp_valid_i = 1'b0; data_i = 32'hDEAD_BEEF;
        check("bp_res_valid", res_valid_o, 1);
        check("bp_res_rdata", res_rdata_o, 32'h99);
        cmd_valid_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h40; cmd_wdata_i = 32'h0000_4444;
        for (int i = 0; i < 4; i++) begin
            check("bp_hold_valid", res_valid_o, 1);
            check("bp_hold_rdata", res_rdata_o, 32'h99);
            check("bp_cmd_ready", cmd_ready_o, 0);
            check("bp_no_req", req_valid_o, 0);
            tick();
        end
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("bp_release_valid", res_valid_o, 0);
        check("bp_release_cmd_ready", cmd_ready_o, 1);
        check("bp_not_yet_req", req_valid_o, 0);
        tick();
        cmd_valid_i = 1'b0;
        check("bp_second_req", req_valid_o, 1);
        check("bp_second_addr", addr_o, 32'h40);
        check("bp_second_we", we_o, 1);
        check("bp_second_data", data_o, 32'h0000_4444);

        // reset while the second command sits in REQ; stray responses afterwards are ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req_valid", req_valid_o, 0);
        check("mid_rst_state", dbg_state_o, 0);
        check("mid_rst_cmd_ready", cmd_ready_o, 1);
        check("mid_rst_res_valid", res_valid_o, 0);
        rsp_valid_i = 1'b1; data_i = 32'h0000_7777;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stray_rsp_res_valid", res_valid_o, 0);
            check("stray_rsp_rdata", res_rdata_o, 0);
            check("stray_rsp_state", dbg_state_o, 0);
        end
        idle_inputs();
        run_vec(vecs[0]);

`ifdef RMW_EN
        // read-modify-write: 0xFF00 read, wdata 0xAA under mask 0x0F0F
        cmd_valid_i = 1'b1; cmd_rmw_i = 1'b1; cmd_we_i = 1'b1; cmd_addr_i = 32'h0;
        cmd_wdata_i = 32'h0000_00AA; cmd_mask_i = 32'h0000_0F0F;
        tick();
        idle_inputs();
        check("rmw_rd_req", req_valid_o, 1);
        check("rmw_rd_we", we_o, 0);
        check("rmw_rd_addr", addr_o, 32'h0);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        check("rmw_rd_rsp_ready", rsp_ready_o, 1);
        rsp_valid_i = 1'b1; data_i = 32'h0000_FF00;
        tick();
        rsp_valid_i = 1'b0; data_i = 32'hDEAD_BEEF;
        check("rmw_wr_req", req_valid_o, 1);
        check("rmw_wr_we", we_o, 1);
        check("rmw_wr_data", data_o, 32'h0000_F00A);
        check("rmw_no_res_yet", res_valid_o, 0);
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        rsp_valid_i = 1'b1; data_i = 32'h1111_1111;
        tick();
        rsp_valid_i = 1'b0;
        check("rmw_res_valid", res_valid_o, 1);
        check("rmw_res_rdata", res_rdata_o, 32'h0000_FF00);
        check("rmw_res_err", res_err_o, 0);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        check("rmw_back_idle", cmd_ready_o, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
